// File: rtl/muli_share_arbiter_pkg.sv
// Shared constants and grant helpers for the shared-multiplier arbiter.
// Optional build macro used by the top: MULI_SHARE_FIXED_PRIO_EN.
package muli_share_arbiter_pkg;

    localparam int MAX_IN = 8;

    // Tag width for a given requester count; never narrower than one bit.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First request strictly after ptr, wrapping modulo n.
    function automatic logic [MAX_IN-1:0] rr_grant(
        input logic [MAX_IN-1:0] req,
        input int                n,
        input int                ptr
    );
        logic [MAX_IN-1:0] gnt;
        int                idx;
        gnt = '0;
        for (int k = 1; k <= MAX_IN; k++) begin
            idx = (ptr + k) % n;
            if (k <= n && gnt == '0 && req[idx])
                gnt[idx] = 1'b1;
        end
        return gnt;
    endfunction

    // Lowest set bit wins.
    function automatic logic [MAX_IN-1:0] fp_grant(input logic [MAX_IN-1:0] req);
        return req & (~req + MAX_IN'(1));
    endfunction

endpackage

// File: rtl/muli_share_arbiter_shared_mul_pipe.sv
// Four-stage unsigned multiplier datapath with a single clock enable:
// operand registers followed by three product stages.
module shared_mul_pipe
    import muli_share_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic [W-1:0] a_q, b_q, p1, p2, p3;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p1  <= '0;
            p2  <= '0;
            p3  <= '0;
        end else if (en) begin
            a_q <= a;
            b_q <= b;
            // Low W bits only; identical for two's-complement operands.
            p1  <= a_q * b_q;
            p2  <= p1;
            p3  <= p2;
        end
    end

    assign p = p3;

endmodule

// File: rtl/muli_share_arbiter.sv
// One shared pipelined multiplier arbitrated among NUM_IN requesters; products
// return to the issuing requester in issue order. Build macro: MULI_SHARE_FIXED_PRIO_EN.
module muli_share_arbiter
    import muli_share_arbiter_pkg::*;
#(
    parameter int NUM_IN    = 2,
    parameter int DATA_TYPE = 32,
    parameter int LATENCY   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN*DATA_TYPE-1:0]   ins_lhs,
    input  logic [NUM_IN-1:0]             ins_lhs_valid,
    input  logic [NUM_IN*DATA_TYPE-1:0]   ins_rhs,
    input  logic [NUM_IN-1:0]             ins_rhs_valid,
    output logic [NUM_IN-1:0]             ins_lhs_ready,
    output logic [NUM_IN-1:0]             ins_rhs_ready,
    output logic [NUM_IN*DATA_TYPE-1:0]   outs_result,
    output logic [NUM_IN-1:0]             outs_valid,
    input  logic [NUM_IN-1:0]             outs_ready
);

    localparam int TAG_W  = tag_width(NUM_IN);
    // Tag/valid line tracks the datapath; only LATENCY = 4 is supported.
    localparam int STAGES = LATENCY - 1;

    logic [NUM_IN-1:0][DATA_TYPE-1:0] lhs, rhs;
    logic [NUM_IN-1:0]                req, grant;
    logic [MAX_IN-1:0]                req_w, grant_w;
    logic [TAG_W-1:0]                 gnt_idx, tail_tag;
    logic [STAGES:0]                  vld_pipe;
    logic [STAGES:0][TAG_W-1:0]       tag_pipe;
    logic [DATA_TYPE-1:0]             issue_lhs, issue_rhs, tail_prod;
    logic                             adv, tail_vld;

    assign lhs = ins_lhs;
    assign rhs = ins_rhs;
    assign req = ins_lhs_valid & ins_rhs_valid;

    assign tail_vld = vld_pipe[STAGES];
    assign tail_tag = tag_pipe[STAGES];
    assign adv      = !tail_vld || outs_ready[tail_tag];

    always_comb begin
        req_w              = '0;
        req_w[NUM_IN-1:0]  = req;
    end

`ifdef MULI_SHARE_FIXED_PRIO_EN
    assign grant_w = fp_grant(req_w);
`else
    logic [TAG_W-1:0] ptr;

    assign grant_w = rr_grant(req_w, NUM_IN, int'(ptr));

    // ptr holds the last winner so the search starts just past it.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= TAG_W'(NUM_IN - 1);
        else if (|grant)
            ptr <= gnt_idx;
    end
`endif

    // A frozen pipeline makes no grant, so ready never leaks during a stall.
    assign grant         = adv ? grant_w[NUM_IN-1:0] : '0;
    assign ins_lhs_ready = grant;
    assign ins_rhs_ready = grant;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (grant[i])
                gnt_idx = TAG_W'(i);
    end

    assign issue_lhs = lhs[gnt_idx];
    assign issue_rhs = rhs[gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], |grant};
            tag_pipe <= {tag_pipe[STAGES-1:0], gnt_idx};
        end
    end

    shared_mul_pipe #(
        .W (DATA_TYPE)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .a   (issue_lhs),
        .b   (issue_rhs),
        .p   (tail_prod)
    );

    for (genvar j = 0; j < NUM_IN; j++) begin : g_out
        assign outs_result[j*DATA_TYPE +: DATA_TYPE] = tail_prod;
        assign outs_valid[j] = tail_vld && (tail_tag == TAG_W'(j));
    end

endmodule

// File: doc/muli_share_arbiter.md
# muli_share_arbiter

Shares one pipelined integer multiplier between NUM_IN independent requesters so that several multiply operations in a dataflow circuit use a single multiplier. The block joins each requester's operand pair and grants one requester per cycle in round-robin order. It carries a requester tag alongside each operation through the pipeline and steers each product back to the issuing requester's output channel. It sits wherever resource sharing replaces several dedicated multiply units with one shared unit.

## Interface
Parameters:
- NUM_IN, 2: number of requesters (2..8).
- DATA_TYPE, 32: operand and result width.
- LATENCY, 4: multiplier latency in cycles; only 4 is supported.

Ports:
- clk  in  1  clock; one clock domain, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ins_lhs  in  NUM_IN*DATA_TYPE  lhs operands; requester i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- ins_lhs_valid  in  NUM_IN  per-requester lhs valid.
- ins_rhs  in  NUM_IN*DATA_TYPE  rhs operands, packed the same way as ins_lhs.
- ins_rhs_valid  in  NUM_IN  per-requester rhs valid.
- ins_lhs_ready  out  NUM_IN  per-requester lhs ready.
- ins_rhs_ready  out  NUM_IN  per-requester rhs ready.
- outs_result  out  NUM_IN*DATA_TYPE  per-requester product, packed the same way as ins_lhs.
- outs_valid  out  NUM_IN  per-requester result valid.
- outs_ready  in  NUM_IN  per-requester result ready.

## Operation
- Request: req[i] = ins_lhs_valid[i] && ins_rhs_valid[i]. Lhs and rhs are always accepted together; neither operand is consumed alone.
- Advance: adv = !tail_valid || outs_ready[tail_tag]. When adv=0, the whole pipeline (data, valid bits, tags) freezes and no grant is made.
- Grant: grant = one-hot, the first i with req[i]=1 searching from ptr+1 upward, wrapping modulo NUM_IN.
- Ready: ins_lhs_ready[i] = ins_rhs_ready[i] = grant[i] && adv. Ready is combinational from the valids; a requester's ready never asserts while its own valid pair is incomplete.
- Issue: on a cycle with a grant and adv=1:
  - the granted operands enter stage 0;
  - tag = i and valid = 1 enter the tag/valid shift line;
  - ptr <= i.
- No issue: on a cycle with adv=1 and no request, a bubble (valid = 0) enters the pipeline.
- Product: the low DATA_TYPE bits of lhs*rhs, unsigned; the result is identical for two's-complement operands.
- Output steering:
  - outs_valid[j] = tail_valid && tail_tag==j;
  - outs_result: every slice carries the tail product; consumers qualify it with outs_valid.
- Ordering: results return in issue order. Head-of-line blocking is intended: a stalled owner stalls everyone.
- Reset:
  - ptr = NUM_IN-1, so requester 0 wins first;
  - all valid bits = 0, so outs_valid = 0;
  - data registers = 0, so outs_result = 0;
  - all ready outputs = 0 while no request is present.
- Reset mid-operation discards all in-flight operations; none of them produces an output.

## Timing
- Latency: an operation issued at rising edge t is presented on outs_valid/outs_result in the cycle after edge t+3. That is 4 cycles after the accept cycle when there are no stalls.
- Throughput: one operation per cycle across all requesters.
- Fairness: with all requesters continuously requesting, each receives exactly one grant every NUM_IN cycles.
- Tail stall: while the tail is valid and its owner holds ready low, the tail product and tag stay stable and all ins_*_ready are 0.
- Simultaneous events: when the tail is consumed and a new issue occur in the same cycle, both happen. Accepting an operation never depends on the same requester's outs_ready.

## Configuration
- MULI_SHARE_FIXED_PRIO_EN defined: the grant is fixed priority, lowest index wins, and ptr is unused and removed.
- Undefined (default): round-robin grant as specified above.

## Structure
- Shared package holds:
  - the tag width constant TAG_W = $clog2(NUM_IN) (minimum 1);
  - a round-robin grant function (requests, pointer) -> one-hot grant.
- Sub-module shared_mul_pipe: 4-stage multiplier datapath with clock-enable (operand registers plus 3 output stages). The arbiter drives its enable with adv.
- Tag/valid shift line, grant logic and output steering live in the top module.

## Test plan
- Single request: requester 1 presents lhs=7, rhs=6 at reset release. Accepted next cycle; outs_valid = 0b010 with product 42 four cycles later; all other outs_valid stay 0.
- Round robin: NUM_IN=3, all requesters continuously valid. Grants go 0,1,2,0,1,2; each requester receives exactly 2 results per 6 cycles, in order.
- Backpressure: requester 0 holds outs_ready=0 when its result reaches the tail. The pipeline freezes and all ready outputs read 0. Release after 5 cycles: product delivered, issue resumes, no loss and no duplication.
- Partial operands: lhs_valid[2]=1, rhs_valid[2]=0. No grant and no ready for requester 2; requester 0 is served meanwhile.
- Wrap and width: 0xFFFFFFFF * 0x00000002 gives 0xFFFFFFFE; 0x80000000 * 0x80000000 gives 0x00000000.
- Reset mid-flight: assert rst with 3 operations in flight. No outs_valid after reset, and requester 0 is granted first afterwards. With MULI_SHARE_FIXED_PRIO_EN defined, continuous requests from 0 and 1 are always granted to 0.
